// File: rtl/mips_multicycle_control.sv
`timescale 1ns/1ps
// mips_multicycle_control
//   Main control FSM and ALU decoder for the non-pipelined multi-cycle MIPS core.
//   It sequences the datapath strobes for lw, sw, R-type, addiu, beq and j.
//   It also runs a valid/ack CHECK handshake on opcode 6'b111111, so that
//   architectural state can be sampled.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   opcode_in, funct_in      instr[31:26] / instr[5:0] as held in the IR
//   zero_in                  ALU zero flag (taken-branch term)
//   check_ack_in             acknowledge for check_valid
//   pc_write .. alu_control  datapath strobes and mux selects
//   check_valid              CHECK handshake request
//   check_timeout            one-cycle pulse when a CHECK is abandoned
//   illegal_op               one-cycle pulse on an unsupported opcode or funct
//   retired_count            legal instructions completed since reset
//   state_out                current state encoding (debug)
module mips_multicycle_control #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned CHECK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode_in,
  input  logic [5:0]       funct_in,
  input  logic             zero_in,
  input  logic             check_ack_in,
  output logic             pc_write,
  output logic             i_or_d,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_control,
  output logic             check_valid,
  output logic             check_timeout,
  output logic             illegal_op,
  output logic [WIDTH-1:0] retired_count,
  output logic [3:0]       state_out
);

  localparam int unsigned CTRL_W = 16;
  localparam int unsigned CNT_W  = (CHECK_TIMEOUT < 2) ? 1 : $clog2(CHECK_TIMEOUT);
  localparam bit          TMO_EN = (CHECK_TIMEOUT != 0);
  // Counter value during the last CHECK cycle allowed before the timeout.
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'((CHECK_TIMEOUT == 0) ? 0 : CHECK_TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_CHECK = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_CHECK  = 4'd12
  } state_t;

  // Moore strobes for a state. The packing is:
  // {pc_write, i_or_d, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
  //  alu_src_a, alu_src_b[1:0], pc_src[1:0], alu_control[2:0], check_valid}.
  function automatic logic [CTRL_W-1:0] moore_ctrl(input state_t s);
    logic       pcw, iod, mw, irw, m2r, rdst, rw, sa, cv;
    logic [1:0] sb, ps;
    logic [2:0] alu;
    pcw = 1'b0; iod = 1'b0; mw = 1'b0; irw = 1'b0; m2r = 1'b0;
    rdst = 1'b0; rw = 1'b0; sa = 1'b0; cv = 1'b0;
    sb = 2'b00; ps = 2'b00; alu = 3'b000;
    case (s)
      S_FETCH:  begin irw = 1'b1; pcw = 1'b1; sb = 2'b01; alu = ALU_ADD; end
      S_DECODE: begin sb = 2'b11; alu = ALU_ADD; end
      S_MEMADR,
      S_ADDIEX: begin sa = 1'b1; sb = 2'b10; alu = ALU_ADD; end
      S_MEMRD:  iod = 1'b1;
      S_MEMWB:  begin m2r = 1'b1; rw = 1'b1; end
      S_MEMWR:  begin iod = 1'b1; mw = 1'b1; end
      S_EXEC:   sa = 1'b1;
      S_ALUWB:  begin rdst = 1'b1; rw = 1'b1; end
      S_BRANCH: begin sa = 1'b1; alu = ALU_SUB; ps = 2'b01; end
      S_ADDIWB: rw = 1'b1;
      S_JUMP:   begin ps = 2'b10; pcw = 1'b1; end
      S_CHECK:  cv = 1'b1;
      default:  ;
    endcase
    return {pcw, iod, mw, irw, m2r, rdst, rw, sa, sb, ps, alu, cv};
  endfunction

  state_t             state_q, state_d;
  logic [CTRL_W-1:0]  ctrl_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic [WIDTH-1:0]   retired_q;
  logic               illegal_c, timeout_c, retire_c, funct_ok_c;
  logic [2:0]         exec_alu_c;

  // ALU decoder for R-type funct fields.
  always_comb begin
    exec_alu_c = ALU_ADD;
    funct_ok_c = 1'b1;
    case (funct_in)
      FN_ADD:  exec_alu_c = ALU_ADD;
      FN_SUB:  exec_alu_c = ALU_SUB;
      FN_AND:  exec_alu_c = ALU_AND;
      FN_OR:   exec_alu_c = ALU_OR;
      FN_SLT:  exec_alu_c = ALU_SLT;
      default: funct_ok_c = 1'b0;
    endcase
  end

  // Next-state logic, plus the retire, illegal and timeout events.
  always_comb begin
    state_d   = state_q;
    illegal_c = 1'b0;
    timeout_c = 1'b0;
    retire_c  = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode_in)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDIU:     state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          OP_CHECK:     state_d = S_CHECK;
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode_in == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_EXEC: begin
        // An unsupported funct skips write-back entirely.
        if (funct_ok_c) begin
          state_d = S_ALUWB;
        end else begin
          state_d   = S_FETCH;
          illegal_c = 1'b1;
        end
      end
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_CHECK: begin
        // An ack takes priority over a timeout that lands in the same cycle.
        if (check_ack_in) begin
          state_d  = S_FETCH;
          retire_c = 1'b1;
        end else if (TMO_EN && (wait_cnt == TMO_LAST)) begin
          state_d   = S_FETCH;
          timeout_c = 1'b1;
        end
      end
      default:  state_d = S_FETCH;
    endcase
  end

  // State, registered Moore strobes (decoded from the next state), and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ctrl_q    <= moore_ctrl(S_FETCH);
      wait_cnt  <= '0;
      retired_q <= '0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= moore_ctrl(state_d);
      wait_cnt <= (state_q == S_CHECK) ? wait_cnt + CNT_W'(1) : '0;
      if (retire_c) retired_q <= retired_q + WIDTH'(1);
    end
  end

  // Every output reads zero while reset is asserted.
  assign pc_write      = ~rst & (ctrl_q[15] | ((state_q == S_BRANCH) & zero_in));
  assign i_or_d        = ~rst & ctrl_q[14];
  assign mem_write     = ~rst & ctrl_q[13];
  assign ir_write      = ~rst & ctrl_q[12];
  assign mem_to_reg    = ~rst & ctrl_q[11];
  assign reg_dst       = ~rst & ctrl_q[10];
  assign reg_write     = ~rst & ctrl_q[9];
  assign alu_src_a     = ~rst & ctrl_q[8];
  assign alu_src_b     = rst ? 2'b00 : ctrl_q[7:6];
  assign pc_src        = rst ? 2'b00 : ctrl_q[5:4];
  assign alu_control   = rst ? 3'b000 : ((state_q == S_EXEC) ? exec_alu_c : ctrl_q[3:1]);
  assign check_valid   = ~rst & ctrl_q[0];
  assign check_timeout = ~rst & timeout_c;
  assign illegal_op    = ~rst & illegal_c;
  assign retired_count = rst ? '0 : retired_q;
  assign state_out     = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
`timescale 1ns/1ps
// Scoreboard bench for mips_multicycle_control. The stimulus side walks a
// per-instruction state sequence and pushes one expected record per cycle.
// The monitor pops and compares one record on every falling edge.
module tb_mips_multicycle_control;

  localparam int TMO = 8;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3,
                 ST_MEMWB = 4, ST_MEMWR = 5, ST_EXEC = 6, ST_ALUWB = 7,
                 ST_BRANCH = 8, ST_ADDIEX = 9, ST_ADDIWB = 10, ST_JUMP = 11,
                 ST_CHECK = 12;

  localparam logic [5:0] OP_RT = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                         OP_ADDIU = 6'b001001, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_CHECK = 6'b111111;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100,
                         FN_OR = 6'b100101, FN_SLT = 6'b101010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode_in = '0;
  logic [5:0]  funct_in = '0;
  logic        zero_in = 1'b0;
  logic        check_ack_in = 1'b0;
  logic        pc_write, i_or_d, mem_write, ir_write, mem_to_reg, reg_dst, reg_write;
  logic        alu_src_a, check_valid, check_timeout, illegal_op;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_control;
  logic [31:0] retired_count;
  logic [3:0]  state_out;

  mips_multicycle_control #(.WIDTH(32), .CHECK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .opcode_in(opcode_in), .funct_in(funct_in),
    .zero_in(zero_in), .check_ack_in(check_ack_in),
    .pc_write(pc_write), .i_or_d(i_or_d), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_control(alu_control), .check_valid(check_valid),
    .check_timeout(check_timeout), .illegal_op(illegal_op),
    .retired_count(retired_count), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] ctl;
    logic [1:0]  flags;   // {illegal_op, check_timeout}
    logic [31:0] ret;
    string       tag;
  } exp_t;

  exp_t        expq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned model_ret = 0;
  int          alu_of_funct [logic [5:0]];

  // Strobe table, using the same field order as the monitor's packing of the DUT outputs.
  function automatic logic [15:0] ref_ctl(input int st, input logic [5:0] fn, input logic z);
    logic pcw, iod, mw, irw, m2r, rd, rw, sa, cv;
    logic [1:0] sb, ps;
    logic [2:0] alu;
    pcw = 0; iod = 0; mw = 0; irw = 0; m2r = 0; rd = 0; rw = 0; sa = 0; cv = 0;
    sb = 2'b00; ps = 2'b00; alu = 3'b000;
    case (st)
      ST_FETCH:  begin pcw = 1; irw = 1; sb = 2'b01; alu = 3'b010; end
      ST_DECODE: begin sb = 2'b11; alu = 3'b010; end
      ST_MEMADR, ST_ADDIEX: begin sa = 1; sb = 2'b10; alu = 3'b010; end
      ST_MEMRD:  iod = 1;
      ST_MEMWB:  begin m2r = 1; rw = 1; end
      ST_MEMWR:  begin iod = 1; mw = 1; end
      ST_EXEC:   begin
        sa = 1;
        alu = alu_of_funct.exists(fn) ? 3'(alu_of_funct[fn]) : 3'b010;
      end
      ST_ALUWB:  begin rd = 1; rw = 1; end
      ST_BRANCH: begin sa = 1; alu = 3'b110; ps = 2'b01; pcw = z; end
      ST_ADDIWB: rw = 1;
      ST_JUMP:   begin ps = 2'b10; pcw = 1; end
      ST_CHECK:  cv = 1;
      default:   ;
    endcase
    return {pcw, iod, mw, irw, m2r, rd, rw, sa, sb, ps, alu, cv};
  endfunction

  function automatic bit is_legal_op(input logic [5:0] o);
    case (o)
      OP_RT, OP_J, OP_BEQ, OP_ADDIU, OP_LW, OP_SW, OP_CHECK: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One clock of stimulus, plus the expected record for that cycle.
  task automatic cycle(input logic [5:0] op, input logic [5:0] fn, input int st,
                       input logic ack, input int zsel, input bit ill, input bit tmo,
                       input string tag);
    logic z;
    exp_t e;
    @(posedge clk);
    #1;
    z = (zsel < 0) ? 1'($urandom) : 1'(zsel);
    rst = 1'b0;
    opcode_in = op;
    funct_in = fn;
    zero_in = z;
    check_ack_in = ack;
    e.st = 4'(st);
    e.ctl = ref_ctl(st, fn, z);
    e.flags = {ill, tmo};
    e.ret = model_ret;
    e.tag = tag;
    expq.push_back(e);
  endtask

  task automatic do_reset(input int n, input string tag);
    exp_t e;
    model_ret = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      opcode_in = 6'($urandom);
      funct_in = 6'($urandom);
      zero_in = 1'($urandom);
      check_ack_in = 1'($urandom);
      e.st = 4'd0; e.ctl = 16'h0; e.flags = 2'b00; e.ret = 32'd0; e.tag = tag;
      expq.push_back(e);
    end
  endtask

  // ack_at: the CHECK cycle (1-based) that gets the ack; 0 or beyond TMO means no ack.
  // cut: if > 0, stop after that many cycles (the instruction is abandoned).
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input int ack_at,
                       input int cut, input int zsel, input string tag);
    int seq[$];
    bit legal;
    bit last, ill, tmo;
    logic ack;
    int n;
    legal = 1'b1;
    seq.push_back(ST_FETCH);
    seq.push_back(ST_DECODE);
    case (op)
      OP_LW:    begin seq.push_back(ST_MEMADR); seq.push_back(ST_MEMRD); seq.push_back(ST_MEMWB); end
      OP_SW:    begin seq.push_back(ST_MEMADR); seq.push_back(ST_MEMWR); end
      OP_RT:    begin
        seq.push_back(ST_EXEC);
        if (alu_of_funct.exists(fn)) seq.push_back(ST_ALUWB);
        else legal = 1'b0;
      end
      OP_BEQ:   seq.push_back(ST_BRANCH);
      OP_ADDIU: begin seq.push_back(ST_ADDIEX); seq.push_back(ST_ADDIWB); end
      OP_J:     seq.push_back(ST_JUMP);
      OP_CHECK: begin
        legal = (ack_at >= 1 && ack_at <= TMO);
        n = legal ? ack_at : TMO;
        for (int k = 0; k < n; k++) seq.push_back(ST_CHECK);
      end
      default:  legal = 1'b0;
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      if (cut > 0 && i == cut) return;
      last = (i == seq.size() - 1);
      ill = last && !legal && (seq[i] != ST_CHECK);
      tmo = last && !legal && (seq[i] == ST_CHECK);
      ack = (seq[i] == ST_CHECK) ? ((i - 1) == ack_at) : 1'($urandom);
      if (i == 0)
        cycle(6'($urandom), 6'($urandom), seq[i], ack, zsel, 1'b0, 1'b0, tag);
      else
        cycle(op, fn, seq[i], ack, zsel, ill, tmo, tag);
    end
    if (legal) model_ret++;
  endtask

  // Monitor: one expected record per falling edge while any are queued.
  initial begin
    exp_t e;
    logic [15:0] act_ctl;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        act_ctl = {pc_write, i_or_d, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
                   alu_src_a, alu_src_b, pc_src, alu_control, check_valid};
        n_cmp++;
        if (state_out !== e.st) begin
          n_bad++;
          $display("FAIL %s state_out: got %0d want %0d", e.tag, state_out, e.st);
        end
        n_cmp++;
        if (act_ctl !== e.ctl) begin
          n_bad++;
          $display("FAIL %s strobes (state %0d): got %h want %h", e.tag, e.st, act_ctl, e.ctl);
        end
        n_cmp++;
        if ({illegal_op, check_timeout} !== e.flags) begin
          n_bad++;
          $display("FAIL %s illegal/timeout: got %b want %b", e.tag,
                   {illegal_op, check_timeout}, e.flags);
        end
        n_cmp++;
        if (retired_count !== e.ret) begin
          n_bad++;
          $display("FAIL %s retired_count: got %0d want %0d", e.tag, retired_count, e.ret);
        end
      end
    end
  end

  initial begin
    logic [5:0] op, fn;
    alu_of_funct[FN_ADD] = 2;
    alu_of_funct[FN_SUB] = 6;
    alu_of_funct[FN_AND] = 0;
    alu_of_funct[FN_OR]  = 1;
    alu_of_funct[FN_SLT] = 7;

    do_reset(2, "por");
    issue(OP_LW,    6'($urandom), 0, 0, -1, "lw");
    issue(OP_SW,    6'($urandom), 0, 0, -1, "sw");
    issue(OP_RT,    FN_ADD,       0, 0, -1, "add");
    issue(OP_ADDIU, 6'($urandom), 0, 0, -1, "addiu");
    issue(OP_LW,    6'($urandom), 0, 3, -1, "lw_cut");
    do_reset(3, "rst_mid_lw");
    issue(OP_BEQ, 6'($urandom), 0, 0, 1, "beq_taken");
    issue(OP_BEQ, 6'($urandom), 0, 0, 0, "beq_not_taken");
    issue(OP_RT, FN_SUB, 0, 0, -1, "sub");
    issue(OP_RT, FN_AND, 0, 0, -1, "and");
    issue(OP_RT, FN_OR,  0, 0, -1, "or");
    issue(OP_RT, FN_SLT, 0, 0, -1, "slt");
    issue(OP_RT, 6'b000000, 0, 0, -1, "funct_illegal");
    issue(OP_CHECK, 6'($urandom), 4, 0, -1, "check_ack4");
    issue(OP_CHECK, 6'($urandom), 0, 0, -1, "check_timeout");
    issue(OP_CHECK, 6'($urandom), TMO, 0, -1, "check_ack_at_limit");
    issue(OP_CHECK, 6'($urandom), 1, 0, -1, "check_ack1");
    issue(6'b000011, 6'($urandom), 0, 0, -1, "op_illegal");
    issue(OP_J, 6'($urandom), 0, 0, -1, "j");

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 7))
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_RT;
        3: op = OP_BEQ;
        4: op = OP_ADDIU;
        5: op = OP_J;
        6: op = OP_CHECK;
        default: begin
          op = 6'($urandom);
          while (is_legal_op(op)) op = 6'($urandom);
        end
      endcase
      if (op == OP_RT && $urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 4))
          0: fn = FN_ADD;
          1: fn = FN_SUB;
          2: fn = FN_AND;
          3: fn = FN_OR;
          default: fn = FN_SLT;
        endcase
      end else begin
        fn = 6'($urandom);
      end
      issue(op, fn, int'($urandom_range(0, 10)), 0, -1, "rand");
    end

    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d records left, want 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
